button_scanner: RTL and testbench

BUTTON_SCANNER -- requirements
Module: button_scanner

---
 rtl/button_scanner.sv | 159 +++++++++++++++
 tb/tb_button_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_scanner.sv
// Scans an external parallel-in/serial-out button register, debounces every bit
// across frames and exposes buttons/changed over an Avalon-MM slave with a level irq.
module button_scanner #(
    parameter int NBITS          = 16,
    parameter int CLK_DIV        = 25,
    parameter int SCAN_GAP       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        shiftreg_clk,
    output logic        shiftreg_loadn,
    input  logic        shiftreg_out,
    input  logic        avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int CNT_MAX = (SCAN_GAP > CLK_DIV) ? SCAN_GAP : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {GAP, LOAD, LOW, HIGH, UPDATE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_phase;
    logic [IW-1:0]    r_idx;
    logic             r_sclk;
    logic             r_loadn;
    logic [NBITS-1:0] r_raw;
    logic [NBITS-1:0] r_buttons;
    logic [NBITS-1:0] r_changed;
    logic [3:0]       r_db_cnt [NBITS];
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [3:0]       w_db_next [NBITS];
    logic [NBITS-1:0] w_toggle;
    logic [NBITS-1:0] w_clear;
    logic             w_gap_done;
    logic             w_div_done;
    logic [IW-1:0]    w_raw_pos;

    assign w_gap_done = (r_phase == CW'(SCAN_GAP - 1));
    assign w_div_done = (r_phase == CW'(CLK_DIV - 1));
    // First bit shifted out is the MSB of the frame.
    assign w_raw_pos  = IW'(NBITS - 1) - r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= GAP;
            r_phase <= '0;
            r_idx   <= '0;
            r_sclk  <= 1'b0;
            r_loadn <= 1'b1;
            r_raw   <= '0;
        end else begin
            r_phase <= r_phase + CW'(1);
            case (r_state)
                GAP: begin
                    if (w_gap_done) begin
                        r_state <= LOAD;
                        r_phase <= '0;
                        r_loadn <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_div_done) begin
                        r_state <= LOW;
                        r_phase <= '0;
                        r_idx   <= '0;
                        r_loadn <= 1'b1;
                    end
                end
                LOW: begin
                    if (w_div_done) begin
                        r_state          <= HIGH;
                        r_phase          <= '0;
                        r_sclk           <= 1'b1;
                        r_raw[w_raw_pos] <= ~shiftreg_out;
                    end
                end
                HIGH: begin
                    if (w_div_done) begin
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        if (r_idx == IW'(NBITS - 1)) begin
                            r_state <= UPDATE;
                        end else begin
                            r_state <= LOW;
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end
                UPDATE: begin
                    r_state <= GAP;
                    r_phase <= '0;
                end
                default: begin
                    r_state <= GAP;
                    r_phase <= '0;
                    r_sclk  <= 1'b0;
                    r_loadn <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_toggle = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            w_db_next[i] = r_db_cnt[i];
            if (r_state == UPDATE) begin
                if (r_raw[i] != r_buttons[i]) begin
                    if (r_db_cnt[i] == 4'(DEBOUNCE_SCANS - 1)) begin
                        w_toggle[i]  = 1'b1;
                        w_db_next[i] = '0;
                    end else begin
                        w_db_next[i] = r_db_cnt[i] + 4'd1;
                    end
                end else begin
                    w_db_next[i] = '0;
                end
            end
        end
    end

    assign w_clear = (avs_read && avs_address) ? r_changed : '0;

    // Set from a toggle overrides a read-clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buttons  <= '0;
            r_changed  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
            for (int unsigned i = 0; i < NBITS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_buttons <= r_buttons ^ w_toggle;
            r_changed <= (r_changed & ~w_clear) | w_toggle;
            r_irq     <= |r_changed;
            for (int unsigned i = 0; i < NBITS; i++) begin
                r_db_cnt[i] <= w_db_next[i];
            end
            if (avs_read) begin
                r_readdata <= avs_address ? 32'(r_changed) : 32'(r_buttons);
            end
        end
    end

    assign shiftreg_clk   = r_sclk;
    assign shiftreg_loadn = r_loadn;
    assign avs_readdata   = r_readdata;
    assign irq            = r_irq;

endmodule

// File: tb/tb_button_scanner.sv
// Bench for button_scanner: 74HC165 model, directed frame-aligned stimulus,
// read responses checked by a scoreboard monitor.
module tb_button_scanner;

    localparam int FRAME = 77;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        shiftreg_clk;
    logic        shiftreg_loadn;
    logic        shiftreg_out;
    logic        avs_address = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    int          irq_hits = 0;
    logic        watch = 1'b0;
    logic        phase2 = 1'b0;
    logic [15:0] pins = 16'hFFFF;
    logic [15:0] sr = '1;
    logic [31:0] exp_q [$];
    string       name_q [$];

    button_scanner #(
        .NBITS(16),
        .CLK_DIV(2),
        .SCAN_GAP(10),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .shiftreg_clk(shiftreg_clk),
        .shiftreg_loadn(shiftreg_loadn),
        .shiftreg_out(shiftreg_out),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // 74HC165: async parallel load while loadn low, shift towards QH on clock rise.
    always @(posedge shiftreg_clk or negedge shiftreg_loadn) begin
        if (!shiftreg_loadn) sr <= pins;
        else                 sr <= {sr[14:0], 1'b1};
    end
    assign shiftreg_out = sr[15];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [15:0] pattern(input int f);
        logic [15:0] p;
        p = 16'hFFFF;
        if (phase2) return 16'h7FE6;
        if (f >= 1) p[0] = 1'b0;
        if (f == 4 || f == 6 || f == 8 || f == 10 || f == 11) p[1] = 1'b0;
        if (f >= 13) p[15] = 1'b0;
        if (f >= 15) p[4] = 1'b0;
        if (f >= 16) p[3] = 1'b0;
        return p;
    endfunction

    // Pins only change early in GAP, well before the next load.
    always @(negedge clk) begin
        if (reset_n && (cyc % FRAME) == 1) pins = pattern(cyc / FRAME);
    end

    always @(negedge clk) begin
        if (watch && irq) irq_hits++;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
        if (cyc != c) begin
            checks++;
            errors++;
            $display("FAIL sched: at cycle %0d, wanted %0d", cyc, c);
        end
    endtask

    task automatic rd(input logic a, input logic [31:0] exp, input string n);
        exp_q.push_back(exp);
        name_q.push_back(n);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
    endtask

    // Scoreboard monitor: a read strobe seen at an edge must produce data one cycle later.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(posedge clk);
            if (avs_read) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%08h, expected no read", avs_readdata);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    chk(n, avs_readdata, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: cycle %0d, expected run to finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int lerr;
        int serr;
        logic exp_l;
        logic exp_s;

        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(shiftreg_clk), 32'd0);
        chk("rst_loadn", 32'(shiftreg_loadn), 32'd1);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;

        lerr = 0;
        serr = 0;
        for (int c = 0; c <= 90; c++) begin
            at(c);
            exp_l = !((c >= 10 && c <= 11) || (c >= 87 && c <= 88));
            exp_s = (c >= 12 && c <= 75 && ((c - 12) % 4) >= 2);
            if (shiftreg_loadn !== exp_l) lerr++;
            if (shiftreg_clk !== exp_s) serr++;
        end
        chk("loadn_trace", 32'(lerr), 32'd0);
        chk("sclk_trace", 32'(serr), 32'd0);

        at(300);  rd(1'b0, 32'h0, "btn_two_frames");
        at(308);  rd(1'b0, 32'h1, "btn_bit0");
        chk("irq_set0", 32'(irq), 32'd1);
        at(310);  rd(1'b1, 32'h1, "chg_bit0");
        at(313);
        chk("irq_clr0", 32'(irq), 32'd0);
        chk("rdata_hold", avs_readdata, 32'h1);
        at(314);  rd(1'b1, 32'h0, "chg_cleared");

        at(315);  watch = 1'b1;
        at(1010); rd(1'b0, 32'h1, "btn_bounce");
        at(1012); rd(1'b1, 32'h0, "chg_bounce");
        at(1230); watch = 1'b0;
        chk("irq_bounce", 32'(irq_hits), 32'd0);

        at(1232);
        chk("irq_lat0", 32'(irq), 32'd0);
        rd(1'b1, 32'h8000, "chg_bit15");
        chk("irq_lat1", 32'(irq), 32'd1);
        at(1235);
        chk("irq_clr15", 32'(irq), 32'd0);
        at(1236); rd(1'b1, 32'h0, "chg_clr15");
        at(1238); rd(1'b0, 32'h8001, "btn_bit15");

        at(1462); rd(1'b1, 32'h10, "collide_rd");
        at(1464); rd(1'b1, 32'h8, "collide_keep");
        at(1466); rd(1'b0, 32'h8019, "btn_all");

        at(1505);
        chk("sclk_high8", 32'(shiftreg_clk), 32'd1);
        #2 reset_n = 1'b0;
        phase2 = 1'b1;
        #1;
        chk("mid_rst_sclk", 32'(shiftreg_clk), 32'd0);
        chk("mid_rst_loadn", 32'(shiftreg_loadn), 32'd1);
        chk("mid_rst_rdata", avs_readdata, 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        at(2);    rd(1'b0, 32'h0, "btn_after_rst");
        at(9);    chk("rst_gap9", 32'(shiftreg_loadn), 32'd1);
        at(10);   chk("rst_load10", 32'(shiftreg_loadn), 32'd0);
        at(11);   chk("rst_load11", 32'(shiftreg_loadn), 32'd0);
        at(12);   chk("rst_low12", 32'(shiftreg_loadn), 32'd1);
        at(14);   chk("rst_sclk14", 32'(shiftreg_clk), 32'd1);
        at(229);  rd(1'b0, 32'h0, "btn_relearn_pre");
        at(231);  rd(1'b0, 32'h8019, "btn_relearn");
        chk("irq_relearn", 32'(irq), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
